// File: rtl/l2_sched_pkg.sv
// l2_pmem_scheduler shared types: line geometry, FSM states,
// write-back buffer entry layout and line-address helper.
package l2_sched_pkg;

  localparam int LINE_OFF = 5;
  localparam int LINE_W = 8 * (2 ** LINE_OFF);

  typedef enum logic [1:0] {
    IDLE,
    PMEM_RD,
    DRAIN,
    RESP
  } state_e;

  typedef logic [31:LINE_OFF] tag_t;

  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [LINE_W-1:0] data;
  } wb_entry_t;

  function automatic tag_t line_addr(input logic [31:0] addr);
    return addr[31:LINE_OFF];
  endfunction

endpackage

// File: rtl/l2_pmem_scheduler_writeback_buffer.sv
// Coalescing write-back FIFO with a parallel tag lookup over
// all valid entries; coalesce rewrites data in place.
module writeback_buffer
  import l2_sched_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:LINE_OFF]          lookup_tag,
  output logic                        hit,
  output logic [$clog2(WB_DEPTH)-1:0] hit_index,
  output logic [LINE_W-1:0]           hit_data,
  input  logic                        coal_en,
  input  logic [$clog2(WB_DEPTH)-1:0] coal_index,
  input  logic [LINE_W-1:0]           wr_data,
  input  logic                        enq_en,
  input  logic                        pop_en,
  output logic [31:LINE_OFF]          head_tag,
  output logic [LINE_W-1:0]           head_data,
  output logic                        full,
  output logic                        empty
);

  localparam int IW = $clog2(WB_DEPTH);

  wb_entry_t     ent [WB_DEPTH];
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [IW:0]   count;

  assign full = count == (IW+1)'(WB_DEPTH);
  assign empty = count == '0;
  assign head_tag = ent[head].tag;
  assign head_data = ent[head].data;

  always_comb begin
    hit = 1'b0;
    hit_index = '0;
    hit_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (ent[i].valid && ent[i].tag == lookup_tag) begin
        hit = 1'b1;
        hit_index = IW'(i);
        hit_data = ent[i].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      if (coal_en) begin
        ent[coal_index].data <= wr_data;
      end
      if (enq_en) begin
        ent[tail].valid <= 1'b1;
        ent[tail].tag <= lookup_tag;
        ent[tail].data <= wr_data;
        tail <= tail + IW'(1);
        count <= count + (IW+1)'(1);
      end else if (pop_en) begin
        ent[head].valid <= 1'b0;
        head <= head + IW'(1);
        count <= count - (IW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/l2_pmem_scheduler.sv
// L2-to-pmem scheduler: reads first, write-backs drained when idle.
// WB_FORWARD_EN: serve read hits from the buffer instead of draining.
module l2_pmem_scheduler
  import l2_sched_pkg::*;
#(
  parameter int s_offset = LINE_OFF,
  parameter int s_line   = LINE_W,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_line-1:0] mem_wdata,
  output logic              mem_resp,
  output logic [s_line-1:0] mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [s_line-1:0] pmem_rdata,
  output logic              wb_full,
  output logic              wb_empty
);

  state_e state, state_n;

  logic                        hit;
  logic [$clog2(WB_DEPTH)-1:0] hit_index;
  logic [s_line-1:0]           hit_data;
  logic [s_line-1:0]           head_data;
  logic [31:s_offset]          head_tag;
  logic                        coal_en;
  logic                        enq_en;
  logic                        pop_en;
  logic                        full;
  logic                        empty;
  logic                        ld_hit;
  logic                        ld_pmem;
  logic                        fwd;
  logic                        unused_ok;

`ifdef WB_FORWARD_EN
  assign fwd = 1'b1;
`else
  assign fwd = 1'b0;
`endif

  assign unused_ok = ^mem_address[s_offset-1:0];

  writeback_buffer #(
    .WB_DEPTH(WB_DEPTH)
  ) u_wb (
    .clk       (clk),
    .rst_n     (rst_n),
    .lookup_tag(line_addr(mem_address)),
    .hit       (hit),
    .hit_index (hit_index),
    .hit_data  (hit_data),
    .coal_en   (coal_en),
    .coal_index(hit_index),
    .wr_data   (mem_wdata),
    .enq_en    (enq_en),
    .pop_en    (pop_en),
    .head_tag  (head_tag),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mem_rdata <= '0;
    end else begin
      state <= state_n;
      if (ld_hit) begin
        mem_rdata <= hit_data;
      end else if (ld_pmem) begin
        mem_rdata <= pmem_rdata;
      end
    end
  end

  always_comb begin
    state_n = state;
    coal_en = 1'b0;
    enq_en = 1'b0;
    pop_en = 1'b0;
    ld_hit = 1'b0;
    ld_pmem = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read) begin
          // without forwarding, drain until the line is gone from the buffer
          if (hit && fwd) begin
            ld_hit = 1'b1;
            state_n = RESP;
          end else if (hit) begin
            state_n = DRAIN;
          end else begin
            state_n = PMEM_RD;
          end
        end else if (mem_write) begin
          if (hit) begin
            coal_en = 1'b1;
            state_n = RESP;
          end else if (!full) begin
            enq_en = 1'b1;
            state_n = RESP;
          end else begin
            state_n = DRAIN;
          end
        end else if (!empty) begin
          state_n = DRAIN;
        end
      end
      PMEM_RD: begin
        if (pmem_resp) begin
          ld_pmem = 1'b1;
          state_n = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          pop_en = 1'b1;
          state_n = IDLE;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mem_resp = state == RESP;
  assign pmem_read = state == PMEM_RD;
  assign pmem_write = state == DRAIN;
  assign wb_full = full;
  assign wb_empty = empty;

  always_comb begin
    pmem_address = '0;
    pmem_wdata = '0;
    if (state == PMEM_RD) begin
      pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
    end else if (state == DRAIN) begin
      pmem_address = {head_tag, {s_offset{1'b0}}};
      pmem_wdata = head_data;
    end
  end

endmodule

// File: tb/tb_l2_pmem_scheduler.sv
// Self-checking bench for l2_pmem_scheduler: directed table,
// corner sequences and a randomized coherence check.
module tb_l2_pmem_scheduler;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_address = '0;
  logic [255:0] mem_wdata = '0;
  logic         mem_resp;
  logic [255:0] mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
  logic [255:0] pmem_rdata = '0;
  logic         wb_full;
  logic         wb_empty;

  int checks = 0;
  int errors = 0;
  int plat = 2;
  int pcnt = 0;

  logic [255:0] pmem_mem [logic [26:0]];
  logic [255:0] ref_mem [logic [26:0]];
  logic [31:0]  rd_log[$];
  logic [31:0]  wa_log[$];
  logic [255:0] wd_log[$];

  always #5 clk = ~clk;

  l2_pmem_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata),
    .wb_full     (wb_full),
    .wb_empty    (wb_empty)
  );

  function automatic logic [255:0] init_val(input logic [26:0] ln);
    return {8{{5'b0, ln}}} ^ {32{8'h5A}};
  endfunction

  function automatic logic [255:0] pmem_val(input logic [26:0] ln);
    if (pmem_mem.exists(ln)) return pmem_mem[ln];
    return init_val(ln);
  endfunction

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // physical memory: responds after plat+1 cycles of a held strobe
  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (pmem_read && pmem_write) begin
      errors++;
      $display("FAIL pmem_rd_wr_both actual=1 required=0");
    end
    if (mem_read && mem_write) begin
      errors++;
      $display("FAIL mem_rd_wr_both actual=1 required=0");
    end
    if (rst_n && (pmem_read || pmem_write)) begin
      if (pcnt >= plat) begin
        pmem_resp = 1'b1;
        pcnt = 0;
        if (pmem_read) begin
          rd_log.push_back(pmem_address);
          pmem_rdata = pmem_val(pmem_address[31:5]);
        end else begin
          wa_log.push_back(pmem_address);
          wd_log.push_back(pmem_wdata);
          pmem_mem[pmem_address[31:5]] = pmem_wdata;
        end
      end else begin
        pcnt++;
      end
    end else begin
      pcnt = 0;
    end
  end

  // latency counted from the first cycle the scheduler is in IDLE
  task automatic req(input bit wr, input logic [31:0] a,
                     input logic [255:0] d,
                     output logic [255:0] rd, output int lat);
    bit b2b;
    b2b = mem_resp;
    mem_read = !wr;
    mem_write = wr;
    mem_address = a;
    mem_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_resp && lat < 200);
    if (!mem_resp) begin
      errors++;
      $display("FAIL req_timeout addr=%0h actual=0 required=1", a);
    end
    if (b2b) lat--;
    rd = mem_rdata;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(wb_empty && !pmem_write && !pmem_read && !mem_resp) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("settle_empty", wb_empty, 1'b1);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
  endtask

  typedef struct {
    bit           settle;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           lat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [255:0] rd;
    int lat;
    logic [26:0] line;
    logic [31:0] a;
    logic [255:0] d;
    bit wr;

    tbl[0]  = '{1, 1, 32'h2000, {32{8'h11}}, 1};
    tbl[1]  = '{0, 0, 32'h2000, {32{8'h11}}, FWD ? 1 : 8};
    tbl[2]  = '{1, 1, 32'h3000, {32{8'h22}}, 1};
    tbl[3]  = '{0, 1, 32'h3000, {32{8'h33}}, 1};
    tbl[4]  = '{0, 0, 32'h3004, {32{8'h33}}, FWD ? 1 : 8};
    tbl[5]  = '{1, 1, 32'h0100, {32{8'h41}}, 1};
    tbl[6]  = '{0, 1, 32'h0200, {32{8'h42}}, 1};
    tbl[7]  = '{0, 1, 32'h0300, {32{8'h43}}, 1};
    tbl[8]  = '{0, 1, 32'h0400, {32{8'h44}}, 1};
    tbl[9]  = '{0, 1, 32'h0500, {32{8'h45}}, 5};
    tbl[10] = '{0, 0, 32'h031F, {32{8'h43}}, FWD ? 1 : 12};
    tbl[11] = '{1, 0, 32'h105F, {32{8'hA5}}, 4};

    repeat (2) @(negedge clk);
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 32'h0);
    check("rst_mem_rdata", mem_rdata, 256'h0);
    check("rst_wb_empty", wb_empty, 1'b1);
    check("rst_wb_full", wb_full, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // read miss on empty buffer, unaligned request address
    pmem_mem[27'h82] = {32{8'hA5}};
    clear_logs();
    req(0, 32'h0000_105F, '0, rd, lat);
    check("t1_rdata", rd, {32{8'hA5}});
    check("t1_lat", lat, 4);
    check("t1_rd_cnt", rd_log.size(), 1);
    check("t1_rd_addr", rd_log.size() > 0 ? rd_log[0] : 32'hFFFF_FFFF, 32'h1040);
    check("t1_empty", wb_empty, 1'b1);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].settle) wait_idle();
      req(tbl[i].wr, tbl[i].addr, tbl[i].data, rd, lat);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].data);
    end

    // coalescing: two writes to one line drain once with newest data
    wait_idle();
    clear_logs();
    req(1, 32'h6000, {32{8'h61}}, rd, lat);
    req(1, 32'h6000, {32{8'h62}}, rd, lat);
    check("t3_not_empty", wb_empty, 1'b0);
    check("t3_not_full", wb_full, 1'b0);
    wait_idle();
    check("t3_wr_cnt", wa_log.size(), 1);
    check("t3_wr_addr", wa_log.size() > 0 ? wa_log[0] : 32'hFFFF_FFFF, 32'h6000);
    check("t3_wr_data", wd_log.size() > 0 ? wd_log[0] : '0, {32{8'h62}});

    // full buffer: fifth write waits for the oldest drain
    clear_logs();
    for (int i = 1; i <= 4; i++) begin
      req(1, 32'h100 * i, {32{8'(i)}}, rd, lat);
    end
    check("t4_full", wb_full, 1'b1);
    req(1, 32'h500, {32{8'h05}}, rd, lat);
    check("t4_first_drain_cnt", wa_log.size(), 1);
    check("t4_first_drain", wa_log.size() > 0 ? wa_log[0] : 32'hFFFF_FFFF, 32'h100);
    wait_idle();
    check("t4_drain_cnt", wa_log.size(), 5);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("t4_order%0d", i),
            wa_log.size() > i ? wa_log[i] : 32'hFFFF_FFFF, 32'h100 * (i + 1));
    end

    // async reset in the middle of a drain
    clear_logs();
    req(1, 32'h7000, {32{8'h71}}, rd, lat);
    req(1, 32'h7100, {32{8'h72}}, rd, lat);
    lat = 0;
    while (!pmem_write && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t6_drain_seen", pmem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_pmem_write_drop", pmem_write, 1'b0);
    check("t6_addr_drop", pmem_address, 32'h0);
    check("t6_empty", wb_empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    req(0, 32'h7000, '0, rd, lat);
    check("t6_rd_lat", lat, 4);
    check("t6_rd_cnt", rd_log.size(), 1);
    check("t6_wr_cnt", wa_log.size(), 0);
    check("t6_rdata", rd, init_val(27'h380));

    // random traffic over eight lines against a flat memory model
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      plat = $urandom_range(0, 3);
      line = 27'h400 + 27'($urandom_range(0, 7));
      a = {line, 5'($urandom())};
      wr = 1'($urandom_range(0, 1));
      d = {8{$urandom()}};
      req(wr, a, d, rd, lat);
      check("rand_lat_bound", lat <= 40, 1'b1);
      if (wr) begin
        ref_mem[line] = d;
      end else begin
        check("rand_rdata", rd, ref_mem.exists(line) ? ref_mem[line] : init_val(line));
      end
    end
    wait_idle();
    foreach (ref_mem[k]) begin
      check($sformatf("final_mem_%0h", k), pmem_val(k), ref_mem[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/l2_pmem_scheduler.md
Name: l2_pmem_scheduler

Overview:
Sits between the shared L2 cache's memory-side port and physical memory. Absorbs L2 dirty-line evictions into a small coalescing write-back buffer so L2 read misses are not serialized behind write-backs. Schedules physical-memory traffic: line reads first, buffered write-backs drained when no read is waiting. Serves reads that hit a buffered line directly from the buffer.

Parameters:
s_offset, 5, byte-offset bits per line; line address is addr[31:s_offset]
s_line, 256, line width in bits (8*2**s_offset)
WB_DEPTH, 4, write-back buffer entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  L2 line read request, held until mem_resp
mem_write  in  1  L2 line write-back request, held until mem_resp
mem_address  in  32  L2 request address; low s_offset bits ignored
mem_wdata  in  s_line  write-back line data
mem_resp  out  1  one-cycle completion pulse to L2
mem_rdata  out  s_line  read line data, valid while mem_resp=1
pmem_read  out  1  physical-memory line read
pmem_write  out  1  physical-memory line write
pmem_address  out  32  line-aligned physical-memory address
pmem_wdata  out  s_line  physical-memory write data
pmem_resp  in  1  physical-memory completion pulse
pmem_rdata  in  s_line  physical-memory read data, valid with pmem_resp
wb_full  out  1  buffer holds WB_DEPTH entries (status)
wb_empty  out  1  buffer holds 0 entries (status)

Behaviour:
- Reset (async, rst_n=0): state IDLE, buffer emptied (all valids 0, head/tail/count 0), mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, mem_rdata=0, wb_empty=1, wb_full=0. Reset mid-transaction drops pmem strobes immediately. Buffered lines are lost by design.
- mem_read and mem_write are never asserted together; a bench check flags it as an error.
- Lookup: line-address compare of mem_address[31:s_offset] against all valid entries. At most one entry matches, guaranteed by coalescing.
- States: IDLE, PMEM_RD, DRAIN, RESP.
- IDLE, priority order:
  - mem_read with hit: latch entry data into mem_rdata; go to RESP.
  - mem_read with miss: go to PMEM_RD.
  - mem_write with hit: overwrite the matching entry's data in place (allowed when full); go to RESP.
  - mem_write with miss and not full: enqueue at tail; go to RESP.
  - mem_write with miss and full: go to DRAIN.
  - Otherwise, not empty: go to DRAIN.
- PMEM_RD: pmem_read=1, pmem_address=line-aligned mem_address. On pmem_resp, latch pmem_rdata into mem_rdata; go to RESP.
- DRAIN: pmem_write=1, pmem_address and pmem_wdata from head entry. On pmem_resp, pop head and go to IDLE. A drain in flight is never aborted; a read arriving mid-drain waits.
- RESP: mem_resp=1 for exactly one cycle, then IDLE. L2 drops its request the cycle after mem_resp, so IDLE never re-serves it.
- Latency from request seen in IDLE to mem_resp:
  - read hit or accepted write: 1 cycle.
  - read miss: pmem latency + 1.
  - write when full: one drain, then 1.
- pmem_read and pmem_write are never both 1.
- Count arithmetic: count width is $clog2(WB_DEPTH)+1. Head and tail wrap modulo WB_DEPTH. Enqueue and pop never occur in the same cycle.
- Coalescing leaves the entry's FIFO position unchanged.

Optional Feature:
WB_FORWARD_EN
- Defined: a read hit is served from the buffer as described above.
- Undefined: a read that hits a buffered line goes to DRAIN instead. It repeats head drains until no entry matches, then goes to PMEM_RD. Memory then always returns the newest data.
- Write coalescing is present in both builds.

Decomposition:
- Package l2_sched_pkg holds:
  - the state enum (IDLE, PMEM_RD, DRAIN, RESP);
  - a wb_entry_t struct holding valid, line tag [31:s_offset] and data;
  - the helper function line_addr().
- One sub-module, writeback_buffer, contains:
  - the FIFO storage, head/tail/count, full/empty;
  - the parallel CAM lookup outputs: hit, hit_index, hit_data;
  - coalesce-write and enqueue/pop ports.
- The top level holds the FSM and pmem/mem muxing.

Test Plan:
- Read miss, empty buffer, addr 0x0000_1040, pmem_resp after 3 cycles with 256'hA5.. -> pmem_read with address 0x0000_1040; mem_resp 1 cycle after pmem_resp with rdata 256'hA5..; wb_empty stays 1.
- Write 0x2000 data D1, then read 0x2000 (forward build) -> write resp 1 cycle after request; read resp 1 cycle later with D1; no pmem_read issued.
- Write 0x3000 D1, then write 0x3000 D2, then idle -> count stays 1; exactly one pmem_write to 0x3000 with D2.
- Fill 4 writes 0x100/0x200/0x300/0x400, then write 0x500 -> wb_full=1; pmem_write to 0x100 first; 0x500 resp only after that pmem_resp; final drain order 0x200, 0x300, 0x400, 0x500.
- Non-forward build: buffer holds 0x100, 0x200; read 0x200 -> drains 0x100 then 0x200, then pmem_read 0x200.
- rst_n low during a DRAIN with 2 entries -> pmem_write drops within the same cycle; wb_empty=1; next read goes straight to PMEM_RD.
